// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types for the RV32IM execute stage
package riscv_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-step restoring divider with early-out and sign correction
module div_unit
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic        rem_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  div_state_t  state, state_nxt;
  logic [4:0]  count;
  logic [31:0] quo, rem, divisor;
  logic        q_neg, r_neg, is_rem;

  logic        s_a, s_b, early;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_sh, diff;

  assign s_a    = signed_i & a_i[31];
  assign s_b    = signed_i & b_i[31];
  assign a_abs  = s_a ? (32'd0 - a_i) : a_i;
  assign b_abs  = s_b ? (32'd0 - b_i) : b_i;
  assign early  = (b_i == 32'd0) ||
                  (signed_i && a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF);
  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, divisor};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= DIV_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (start_i) state_nxt = early ? DIV_DONE : DIV_BUSY;
        DIV_BUSY: if (count == 5'd31) state_nxt = DIV_DONE;
        DIV_DONE: state_nxt = DIV_IDLE;
        default:  state_nxt = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_o  = !flush_i && ((state == DIV_IDLE && start_i) || state == DIV_BUSY);
    done_o   = (state == DIV_DONE);
    result_o = is_rem ? (r_neg ? (32'd0 - rem) : rem)
                      : (q_neg ? (32'd0 - quo) : quo);
  end

  // Early-out results are stored pre-corrected, so their sign flags are cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count   <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      is_rem  <= 1'b0;
    end else if (state == DIV_IDLE && start_i && !flush_i) begin
      count   <= '0;
      is_rem  <= rem_i;
      divisor <= b_abs;
      if (b_i == 32'd0) begin
        quo   <= 32'hFFFF_FFFF;
        rem   <= a_i;
        q_neg <= 1'b0;
        r_neg <= 1'b0;
      end else if (early) begin
        quo   <= 32'h8000_0000;
        rem   <= 32'd0;
        q_neg <= 1'b0;
        r_neg <= 1'b0;
      end else begin
        quo   <= a_abs;
        rem   <= 32'd0;
        q_neg <= s_a ^ s_b;
        r_neg <= s_a;
      end
    end else if (state == DIV_BUSY && !flush_i) begin
      count <= count + 5'd1;
      if (!diff[32]) begin
        rem <= diff[31:0];
        quo <= {quo[30:0], 1'b1};
      end else begin
        rem <= rem_sh[31:0];
        quo <= {quo[30:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32IM EX stage with operand forwarding and EX/MEM register
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic [4:0]      alu_op_i,
  input  logic            alu_src_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] mem_fwd_data_i,
  input  logic [XLEN-1:0] wb_fwd_data_i,
  input  logic [1:0]      fwd_rs1_i,
  input  logic [1:0]      fwd_rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            reg_write_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            mem_valid_o,
  output logic [XLEN-1:0] mem_alu_result_o,
  output logic [XLEN-1:0] mem_store_data_o,
  output logic [4:0]      mem_rd_o,
  output logic            mem_reg_write_o,
  output logic            mem_read_o,
  output logic            mem_write_o
);

  alu_op_t         op;
  logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_res, div_res;
  logic [63:0]     mul_a, mul_b, prod;
  logic            div_start, div_done;

  assign op = alu_op_t'(alu_op_i);

  always_comb begin
    case (fwd_rs1_i)
      FWD_MEM: op_a = mem_fwd_data_i;
      FWD_WB:  op_a = wb_fwd_data_i;
      default: op_a = rs1_data_i;
    endcase
    case (fwd_rs2_i)
      FWD_MEM: rs2_fwd = mem_fwd_data_i;
      FWD_WB:  rs2_fwd = wb_fwd_data_i;
      default: rs2_fwd = rs2_data_i;
    endcase
    op_b = alu_src_i ? imm_i : rs2_fwd;
  end

  // Sign-extend to 64 bits so one signed multiply covers all four MUL variants.
  assign mul_a = {{32{op_a[31] & (op == ALU_MULH || op == ALU_MULHSU)}}, op_a};
  assign mul_b = {{32{op_b[31] & (op == ALU_MULH)}}, op_b};
  assign prod  = mul_a * mul_b;

  always_comb begin
    case (op)
      ALU_ADD:    alu_res = op_a + op_b;
      ALU_SUB:    alu_res = op_a - op_b;
      ALU_SLL:    alu_res = op_a << op_b[4:0];
      ALU_SLT:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   alu_res = {31'd0, op_a < op_b};
      ALU_XOR:    alu_res = op_a ^ op_b;
      ALU_SRL:    alu_res = op_a >> op_b[4:0];
      ALU_SRA:    alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_OR:     alu_res = op_a | op_b;
      ALU_AND:    alu_res = op_a & op_b;
      ALU_MUL:    alu_res = prod[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: alu_res = prod[63:32];
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: alu_res = div_res;
      default:    alu_res = '0;
    endcase
  end

  assign div_start = valid_i && is_div_op(op) && !flush_i;

  div_unit u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .start_i  (div_start),
    .signed_i (op == ALU_DIV || op == ALU_REM),
    .rem_i    (op == ALU_REM || op == ALU_REMU),
    .a_i      (op_a),
    .b_i      (op_b),
    .stall_o  (stall_o),
    .done_o   (div_done),
    .result_o (div_res)
  );

  // A divide only reaches EX/MEM from DONE; stall covers its start and BUSY cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_valid_o      <= 1'b0;
      mem_alu_result_o <= '0;
      mem_store_data_o <= '0;
      mem_rd_o         <= '0;
      mem_reg_write_o  <= 1'b0;
      mem_read_o       <= 1'b0;
      mem_write_o      <= 1'b0;
    end else if (flush_i || stall_o || !valid_i || (is_div_op(op) && !div_done)) begin
      mem_valid_o      <= 1'b0;
      mem_reg_write_o  <= 1'b0;
      mem_read_o       <= 1'b0;
      mem_write_o      <= 1'b0;
    end else begin
      mem_valid_o      <= 1'b1;
      mem_alu_result_o <= alu_res;
      mem_store_data_o <= rs2_fwd;
      mem_rd_o         <= rd_i;
      mem_reg_write_o  <= reg_write_i;
      mem_read_o       <= mem_read_i;
      mem_write_o      <= mem_write_i;
    end
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute (EX) stage of the 5-stage RV32IM pipeline, including the EX/MEM pipeline register. It resolves each source operand from the register file, the MEM-stage result or the WB-stage result, using the 2-bit select codes from the forwarding unit. It then computes the ALU/multiply result in one cycle, or runs an iterative 32-step divider that stalls the front end. The registered EX/MEM outputs feed the MEM stage; `mem_rd_o`/`mem_reg_write_o` are the forwarding unit's MEM-side inputs.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk_i  in  1  clock, all state on rising edge`
- `rst_i  in  1  reset, asynchronous, active-high`
- `valid_i  in  1  instruction in EX is real (not a bubble)`
- `alu_op_i  in  5  operation, alu_op_t`
- `alu_src_i  in  1  1: operand B = imm_i, 0: forwarded rs2`
- `rs1_data_i, rs2_data_i  in  32  register-file read data`
- `imm_i  in  32  sign-extended immediate`
- `mem_fwd_data_i, wb_fwd_data_i  in  32  MEM-stage / WB-stage result`
- `fwd_rs1_i, fwd_rs2_i  in  2  forward select: 00 regfile, 10 MEM, 01 WB, 11 treated as 00`
- `rd_i  in  5  destination register`
- `reg_write_i, mem_read_i, mem_write_i  in  1  control passed to MEM`
- `flush_i  in  1  kill instruction in EX (branch mispredict/trap)`
- `stall_o  out  1  hold IF/ID/ID-EX; combinational`
- `mem_valid_o  out  1  EX/MEM valid`
- `mem_alu_result_o  out  32  result`
- `mem_store_data_o  out  32  forwarded rs2 (never imm)`
- `mem_rd_o  out  5`, `mem_reg_write_o, mem_read_o, mem_write_o  out  1`

## Operation
- Operand A = mux(fwd_rs1_i); forwarded rs2 = mux(fwd_rs2_i); operand B = alu_src_i ? imm_i : forwarded rs2.
- Single-cycle ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU.
  - Shift amount is B[4:0].
  - SLT is signed, SLTU is unsigned; both produce 0/1 zero-extended.
  - MUL returns the low 32 bits of the product; the MULH* ops return the high 32 bits of the 64-bit product with RISC-V signedness.
- Divide ops (DIV, DIVU, REM, REMU) go through the divider FSM: IDLE → BUSY → DONE → IDLE.
  - In IDLE, a valid divide with flush_i=0 latches |A|, |B| and the sign flags, sets count=0, and moves to BUSY. stall_o=1 in this cycle.
  - BUSY performs one restoring step per cycle, count 0..31, with stall_o=1. After count 31 the FSM moves to DONE.
  - DONE applies sign correction (quotient sign = sA^sB; remainder sign = sA), drives stall_o=0, and lets EX/MEM latch the result. The FSM returns to IDLE.
- Early-out cases go IDLE → DONE directly, skipping BUSY:
  - Divisor zero: quotient = 0xFFFFFFFF, remainder = A.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- EX/MEM register:
  - When stall_o=1, it loads a bubble: mem_valid_o and all write/read controls are 0, and data is don't-care (held).
  - Otherwise it loads the result and controls, with mem_valid_o = valid_i.
  - An invalid instruction loads a bubble.
- flush_i has priority over everything. The next edge loads a bubble and forces the FSM to IDLE, aborting any divide. stall_o=0 while flush_i=1.

## Timing
- Reset: every EX/MEM output is 0, FSM is IDLE, count is 0, and stall_o is 0.
- Reset asserted mid-divide aborts the divide with no result.
- Single-cycle op: the result is visible one edge after it is presented.
- Divide presented in cycle 0: stall_o is high in cycles 0–32 and low in cycle 33. The result appears after the edge ending cycle 33, so latency is 34 cycles.
- Early-out divide: stall_o is high in cycle 0 only, and the result appears after the edge ending cycle 1.
- Operands are captured in cycle 0. Forwarding inputs changing during BUSY (the pipeline drains) have no effect.
- Because ID/EX is held during a stall, the divide instruction is still presented at DONE. The FSM uses the DONE state to not restart it.
- A divide immediately following another divide starts a fresh IDLE → BUSY sequence in the cycle after DONE.

## Structure
- Package `riscv_pkg`:
  - `alu_op_t` enum, 5 bits.
  - Forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Divider state enum.
- Sub-module `div_unit`: FSM, counter, restoring datapath, early-out and sign correction, with a start/done/busy interface.
- The ALU, multiplier, operand muxes and EX/MEM register stay in `execute_stage`.

## Test plan
- fwd_rs1_i=10, mem_fwd_data_i=5, rs2_data_i=7, ADD, alu_src_i=0 → mem_alu_result_o=12 next cycle. Repeat with fwd=01, wb_fwd_data_i=9 → 16.
- SRA A=0x80000000, imm=0x24 (shamt 4) → 0xF8000000. SLTU A=1, B=0xFFFFFFFF → 1.
- DIV A=-7, B=2 → stall_o high for exactly 33 cycles, then quotient 0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF. mem_valid_o=0 during the stall.
- DIVU A=5, B=0 → 1-cycle stall, result 0xFFFFFFFF. REM A=0x80000000, B=-1 → 0.
- flush_i at BUSY count 10 → bubble, FSM IDLE, stall_o=0 next cycle. A new ADD issued after that completes normally.
- Reset asserted during BUSY → all outputs 0 immediately (asynchronous). After release, MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
